// File: rtl/lcd_spi_pkg.sv
// Shared types and defaults for the character-LCD SPI frame transmitter.
// Frame size matches the display fsm output width (out_size/8).
package lcd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } tx_state_e;

  localparam logic [7:0] NULL_BYTE       = 8'h00;
  localparam logic [7:0] ESC             = 8'h1B;
  localparam int         LCD_FRAME_BYTES = 19;
  localparam int         DEF_SCLK_HALF   = 100;
  localparam int         DEF_BYTE_GAP    = 4000;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SCLK divider plus MSB-first byte shifter (SPI mode 0). done is combinational so
// the frame sequencer leaves SHIFT on the same edge as the eighth falling SCLK edge.
module spi_byte_shifter
  import lcd_spi_pkg::*;
#(
  parameter int SCLK_HALF = DEF_SCLK_HALF,
  parameter int CNT_W     = cnt_width(DEF_SCLK_HALF, DEF_BYTE_GAP)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] byte_in,
  output logic       sclk,
  output logic       mosi,
  output logic       done
);

  logic [CNT_W-1:0] div_cnt;
  logic [6:0]       sh;
  logic [2:0]       bit_idx;
  logic             active;
  logic             wrap;

  assign wrap = (div_cnt == CNT_W'(SCLK_HALF - 1));
  assign done = active && wrap && sclk && (bit_idx == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sh      <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (clear) begin
      div_cnt <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (start) begin
      sh      <= byte_in[6:0];
      mosi    <= byte_in[7];
      bit_idx <= 3'd7;
      div_cnt <= '0;
      sclk    <= 1'b0;
      active  <= 1'b1;
    end else if (active) begin
      if (wrap) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        // falling edge: advance to the next bit; after bit 0 mosi holds its value
        if (sclk) begin
          if (bit_idx == 3'd0) begin
            active <= 1'b0;
          end else begin
            bit_idx <= bit_idx - 3'd1;
            mosi    <= sh[6];
            sh      <= {sh[5:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// Frame sequencer: latches a packed ASCII frame and sends it byte by byte over SPI
// until a NULL byte or FRAME_BYTES bytes, then pulses end_transmission.
module spi_frame_tx
  import lcd_spi_pkg::*;
#(
  parameter int FRAME_BYTES = LCD_FRAME_BYTES,
  parameter int SCLK_HALF   = DEF_SCLK_HALF,
  parameter int BYTE_GAP    = DEF_BYTE_GAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     begin_transmission,
  input  logic                     slave_select,
  input  logic [8*FRAME_BYTES-1:0] data_in,
  output logic                     end_transmission,
  output logic                     busy,
  output logic                     ss_n,
  output logic                     sclk,
  output logic                     mosi
);

  localparam int CNT_W = cnt_width(SCLK_HALF, BYTE_GAP);
  localparam int IDX_W = $clog2(FRAME_BYTES + 1);

  tx_state_e                state;
  logic [8*FRAME_BYTES-1:0] frame_reg;
  logic [IDX_W-1:0]         byte_idx;
  logic [CNT_W-1:0]         gap_cnt;
  logic [7:0]               cur_byte;
  logic                     abort;
  logic                     frame_end;
  logic                     shift_start;
  logic                     byte_done;

  // frame_reg shifts left after each byte, so the current byte is always the top one
  assign cur_byte    = frame_reg[8*FRAME_BYTES-1 -: 8];
  assign abort       = (state != ST_IDLE) && slave_select;
  assign frame_end   = (cur_byte == NULL_BYTE) || (byte_idx == IDX_W'(FRAME_BYTES));
  assign shift_start = (state == ST_CHECK) && !abort && !frame_end;

  spi_byte_shifter #(
    .SCLK_HALF (SCLK_HALF),
    .CNT_W     (CNT_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (shift_start),
    .clear   (abort),
    .byte_in (cur_byte),
    .sclk    (sclk),
    .mosi    (mosi),
    .done    (byte_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      frame_reg        <= '0;
      byte_idx         <= '0;
      gap_cnt          <= '0;
      ss_n             <= 1'b1;
      busy             <= 1'b0;
      end_transmission <= 1'b0;
    end else begin
      end_transmission <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        ss_n  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (begin_transmission && !slave_select) begin
            frame_reg <= data_in;
            byte_idx  <= '0;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
          ST_LOAD: state <= ST_CHECK;
          ST_CHECK: if (frame_end) begin
            ss_n             <= 1'b1;
            end_transmission <= 1'b1;
            state            <= ST_DONE;
          end else begin
            ss_n  <= 1'b0;
            state <= ST_SHIFT;
          end
          ST_SHIFT: if (byte_done) begin
            byte_idx  <= byte_idx + IDX_W'(1);
            frame_reg <= frame_reg << 8;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
          ST_GAP: if (gap_cnt == CNT_W'(BYTE_GAP - 1)) state <= ST_CHECK;
                  else gap_cnt <= gap_cnt + CNT_W'(1);
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: an LCD model samples MOSI on SCLK rise while ss_n is low.
module tb_spi_frame_tx;
  localparam int FB = 19;

  logic          clk;
  logic          rst;
  logic          begin_transmission;
  logic          slave_select;
  logic [8*FB-1:0] data_in;
  logic          end_transmission;
  logic          busy;
  logic          ss_n;
  logic          sclk;
  logic          mosi;

  int n_chk = 0;
  int n_err = 0;

  spi_frame_tx #(.FRAME_BYTES(FB), .SCLK_HALF(2), .BYTE_GAP(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .begin_transmission (begin_transmission),
    .slave_select       (slave_select),
    .data_in            (data_in),
    .end_transmission   (end_transmission),
    .busy               (busy),
    .ss_n               (ss_n),
    .sclk               (sclk),
    .mosi               (mosi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LCD model and event counters (cumulative; tests work on deltas)
  logic [7:0] rx_log [0:1023];
  logic [7:0] rx_sh;
  int rx_bits  = 0;
  int rx_cnt   = 0;
  int n_rise   = 0;
  int n_end    = 0;
  int n_ssfall = 0;

  always @(posedge sclk or posedge ss_n) begin
    if (ss_n) begin
      rx_bits <= 0;
    end else begin
      rx_sh <= {rx_sh[6:0], mosi};
      if (rx_bits == 7) begin
        if (rx_cnt < 1024) rx_log[rx_cnt] <= {rx_sh[6:0], mosi};
        rx_cnt  <= rx_cnt + 1;
        rx_bits <= 0;
      end else begin
        rx_bits <= rx_bits + 1;
      end
    end
  end

  always @(posedge sclk) n_rise <= n_rise + 1;
  always @(negedge ss_n) n_ssfall <= n_ssfall + 1;
  always @(negedge clk) if (end_transmission) n_end <= n_end + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns after the edge that samples begin_transmission
  task automatic start_frame(input logic [8*FB-1:0] frm);
    data_in = frm;
    begin_transmission = 1'b1;
    tick();
    begin_transmission = 1'b0;
  endtask

  task automatic wait_end(input int limit, output int n);
    n = 0;
    while (!end_transmission && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic check_rx(input string tag, input int base, input logic [8*FB-1:0] frm, input int n);
    check({tag, "_count"}, 64'(rx_cnt - base), 64'(n));
    for (int i = 0; i < n; i++)
      check(tag, {56'd0, rx_log[(base + i) % 1024]}, {56'd0, frm[8*(FB-1-i) +: 8]});
  endtask

  logic [8*FB-1:0] f_hello, f_short, f_null, f_congr;
  int base, e0, r0, s0, cyc;

  initial begin
    f_hello = {8'h1B, 8'h5B, 8'h6A, 8'h31, 8'h32, 8'h33, 8'h34, {11{8'h20}}, 8'h00};
    f_short = {8'h1B, 8'h5B, 8'h6A, 8'h00, {15{8'h41}}};
    f_null  = {8'h00, {18{8'h41}}};
    f_congr = {"CONGRATULATIONS", 8'h00, 24'h414243};

    rst = 1'b1;
    begin_transmission = 1'b0;
    slave_select = 1'b0;
    data_in = '0;
    tick();
    tick();
    check("rst_ss_n", 64'(ss_n), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_end",  64'(end_transmission), 64'd0);
    rst = 1'b0;
    tick();

    // 1: full 18-byte frame
    base = rx_cnt; e0 = n_end; r0 = n_rise; s0 = n_ssfall;
    start_frame(f_hello);
    check("t1_busy_load", 64'(busy), 64'd1);
    check("t1_ss_load", 64'(ss_n), 64'd1);
    tick();
    check("t1_ss_check", 64'(ss_n), 64'd1);
    tick();
    check("t1_ss_first", 64'(ss_n), 64'd0);
    check("t1_mosi_first", 64'(mosi), 64'd0);
    wait_end(3000, cyc);
    check("t1_latency", 64'(cyc), 64'd666);
    check("t1_end_ss_n", 64'(ss_n), 64'd1);
    tick();
    check("t1_end_pulse_off", 64'(end_transmission), 64'd0);
    check("t1_busy_off", 64'(busy), 64'd0);
    check_rx("t1_byte", base, f_hello, 18);
    check("t1_rises", 64'(n_rise - r0), 64'd144);
    check("t1_ends", 64'(n_end - e0), 64'd1);
    check("t1_ss_falls", 64'(n_ssfall - s0), 64'd1);
    repeat (3) tick();

    // 2: NULL at byte 3
    base = rx_cnt; e0 = n_end;
    start_frame(f_short);
    wait_end(3000, cyc);
    check("t2_latency", 64'(cyc), 64'd113);
    tick();
    check("t2_busy_off", 64'(busy), 64'd0);
    check_rx("t2_byte", base, f_short, 3);
    check("t2_ends", 64'(n_end - e0), 64'd1);
    repeat (3) tick();

    // 3: NULL at byte 0
    e0 = n_end; r0 = n_rise; s0 = n_ssfall;
    start_frame(f_null);
    tick();
    check("t3_end_early", 64'(end_transmission), 64'd0);
    tick();
    check("t3_end_pulse", 64'(end_transmission), 64'd1);
    check("t3_ss_n", 64'(ss_n), 64'd1);
    tick();
    check("t3_end_off", 64'(end_transmission), 64'd0);
    check("t3_busy_off", 64'(busy), 64'd0);
    check("t3_rises", 64'(n_rise - r0), 64'd0);
    check("t3_ss_falls", 64'(n_ssfall - s0), 64'd0);
    check("t3_ends", 64'(n_end - e0), 64'd1);
    repeat (3) tick();

    // 4: re-pulse begin and change data mid-frame, then a new frame after DONE
    base = rx_cnt; e0 = n_end;
    start_frame(f_hello);
    repeat (60) tick();
    start_frame(f_congr);
    wait_end(3000, cyc);
    tick();
    check_rx("t4_orig", base, f_hello, 18);
    check("t4_ends", 64'(n_end - e0), 64'd1);
    base = rx_cnt;
    start_frame(f_congr);
    wait_end(3000, cyc);
    tick();
    check_rx("t4_new", base, f_congr, 15);
    check("t4_ends2", 64'(n_end - e0), 64'd2);
    repeat (3) tick();

    // 5: async reset between edges while SCLK is high in byte 1
    e0 = n_end;
    start_frame(f_hello);
    repeat (45) tick();
    check("t5_pre_sclk", 64'(sclk), 64'd1);
    check("t5_pre_mosi", 64'(mosi), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ss_n", 64'(ss_n), 64'd1);
    check("t5_rst_sclk", 64'(sclk), 64'd0);
    check("t5_rst_mosi", 64'(mosi), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t5_no_end", 64'(n_end - e0), 64'd0);
    base = rx_cnt;
    start_frame(f_hello);
    wait_end(3000, cyc);
    tick();
    check_rx("t5_byte", base, f_hello, 18);
    repeat (3) tick();

    // 6: abort during byte 5, then begin with slave_select high is ignored
    base = rx_cnt; e0 = n_end;
    start_frame(f_hello);
    repeat (190) tick();
    slave_select = 1'b1;
    tick();
    check("t6_ss_n", 64'(ss_n), 64'd1);
    check("t6_sclk", 64'(sclk), 64'd0);
    check("t6_mosi", 64'(mosi), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("t6_bytes", 64'(rx_cnt - base), 64'd5);
    check("t6_no_end", 64'(n_end - e0), 64'd0);
    start_frame(f_hello);
    check("t6_ign_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("t6_ign_ss_n", 64'(ss_n), 64'd1);
    check("t6_ign_busy2", 64'(busy), 64'd0);
    slave_select = 1'b0;
    repeat (3) tick();
    check("t6_idle_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
